// File: rtl/shift_undo.sv
// rtl/shift_undo.sv - undoes 1..4 forward shift/rotate steps on a 4-bit value
// and flags any bit lost by a fill-1 shift that was not actually a 1.
module shift_undo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   input  logic [1:0] in_op,
   input  logic [1:0] in_cnt,
   input  logic       fill_bit,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_data,
   output logic       out_err,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   logic [3:0] r_data;
   logic [1:0] r_op;
   logic [2:0] r_cnt;
   logic       r_err;

   logic [3:0] w_next;
   logic       w_viol;

   // One inverse step; the forward fill-1 shifts must have left a 1 at the
   // edge the inverse shifts out, otherwise the forward data was corrupt.
   always_comb begin
      w_next = r_data;
      w_viol = 1'b0;
      case (r_op)
         2'b01: begin
            w_next = {fill_bit, r_data[3:1]};
            w_viol = ~r_data[0];
         end
         2'b10: begin
            w_next = {r_data[2:0], fill_bit};
            w_viol = ~r_data[3];
         end
         2'b11: w_next = {r_data[2:0], r_data[3]};
         default: w_next = r_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_data  <= 4'd0;
         r_op    <= 2'd0;
         r_cnt   <= 3'd0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_data  <= in_data;
                  r_op    <= in_op;
                  r_cnt   <= {1'b0, in_cnt} + 3'd1;
                  r_err   <= 1'b0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_data <= w_next;
               if (w_viol) r_err <= 1'b1;
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt == 3'd1) r_state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
   assign out_data  = (r_state == S_DONE) ? r_data : 4'd0;
   assign out_err   = (r_state == S_DONE) ? r_err : 1'b0;

endmodule
